// File: rtl/pipe_pkg.sv
// Shared pipeline types: datapath word, register address, load formats,
// IR field positions and the forward-bus payload.
package pipe_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREGS      = 32;
    localparam int unsigned RA_W       = 5;
    localparam int unsigned F3_W       = 3;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [RA_W-1:0] regaddr_t;

    typedef enum logic [F3_W-1:0] {
        LD_B  = 3'b000,
        LD_H  = 3'b001,
        LD_W  = 3'b010,
        LD_BU = 3'b100,
        LD_HU = 3'b101
    } load_fmt_e;

    typedef struct packed {
        logic     en;
        regaddr_t rd;
        word_t    data;
    } fwd_t;

    // Extract and extend the addressed byte/half of a raw DMem word.
    // Misaligned halves use addr[1] only; word loads ignore the offset.
    function automatic word_t format_load(input logic [F3_W-1:0] f3,
                                          input logic [1:0]      off,
                                          input word_t           raw);
        logic [7:0]  b;
        logic [15:0] h;
        word_t       res;
        case (off)
            2'd0:    b = raw[7:0];
            2'd1:    b = raw[15:8];
            2'd2:    b = raw[23:16];
            default: b = raw[31:24];
        endcase
        h = off[1] ? raw[31:16] : raw[15:0];
        case (load_fmt_e'(f3))
            LD_B:    res = {{(XLEN-8){b[7]}}, b};
            LD_H:    res = {{(XLEN-16){h[15]}}, h};
            LD_BU:   res = {{(XLEN-8){1'b0}}, b};
            LD_HU:   res = {{(XLEN-16){1'b0}}, h};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two combinational read ports, one write port,
// x0 hardwired to zero, same-cycle write-through bypass, synchronous clear.
module regfile_2r1w
    import pipe_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [RA_W-1:0]      waddr,
    input  logic [XLEN-1:0]      wdata,
    input  logic [RA_W-1:0]      raddr1,
    input  logic [RA_W-1:0]      raddr2,
    output logic [XLEN-1:0]      rdata1,
    output logic [XLEN-1:0]      rdata2
);

    word_t regs [NREGS];

    logic wr_ok;
    assign wr_ok = we && (waddr != '0);

    // Reset wins over a coincident write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        if (raddr1 != '0) begin
            if (wr_ok && (raddr1 == waddr)) begin
                rdata1 = wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (raddr2 != '0) begin
            if (wr_ok && (raddr2 == waddr)) begin
                rdata2 = wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

endmodule

// File: rtl/stage5_writeback.sv
// Writeback stage: load formatting, register file write, forward bus and
// retire pulse. Define WB_INSTRET_EN to add a 64-bit retired-instruction counter.
module stage5_writeback
    import pipe_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_valid,
    input  logic [31:0]     wb_ir,
    input  logic [XLEN-1:0] wb_alu,
    input  logic [XLEN-1:0] wb_rdata,
    input  logic            wb_load,
    input  logic            wb_regwr,
    input  logic [RA_W-1:0] rs1_addr,
    input  logic [RA_W-1:0] rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_fwd_en,
    output logic [RA_W-1:0] wb_fwd_rd,
    output logic [XLEN-1:0] wb_fwd_data,
    output logic            retired
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]     instret
`endif
);

    regaddr_t         rd;
    logic [F3_W-1:0]  funct3;
    word_t            result;
    logic             we;
    fwd_t             fwd_q;

    assign rd     = wb_ir[RD_LSB +: RA_W];
    assign funct3 = wb_ir[FUNCT3_LSB +: F3_W];

    logic unused_ir;
    assign unused_ir = ^{wb_ir[31:FUNCT3_LSB+F3_W], wb_ir[RD_LSB-1:0]};

    always_comb begin
        result = wb_alu;
        if (wb_load) begin
            result = format_load(funct3, wb_alu[1:0], wb_rdata);
        end
    end

    assign we = wb_valid && wb_regwr && (rd != '0);

    regfile_2r1w u_regfile (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (rd),
        .wdata  (result),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    // Forward bus carries zeros whenever nothing was written.
    always_ff @(posedge clk) begin
        if (reset) begin
            fwd_q   <= '0;
            retired <= 1'b0;
        end else begin
            fwd_q.en   <= we;
            fwd_q.rd   <= we ? rd : '0;
            fwd_q.data <= we ? result : '0;
            retired    <= wb_valid;
        end
    end

    assign wb_fwd_en   = fwd_q.en;
    assign wb_fwd_rd   = fwd_q.rd;
    assign wb_fwd_data = fwd_q.data;

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= '0;
        end else if (wb_valid) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule
